// File: rtl/mem_pkg.sv
// Shared types and default geometry for the cache line responder.
package mem_pkg;

  localparam int unsigned DEF_ADDR_W     = 36;
  localparam int unsigned DEF_WORD_W     = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;

  localparam int unsigned WORD_BYTES    = DEF_WORD_W / 8;
  localparam int unsigned LINE_OFF_BITS = $clog2(DEF_LINE_WORDS * WORD_BYTES);

  typedef logic [DEF_LINE_WORDS-1:0][DEF_WORD_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } resp_state_t;

  typedef enum logic {
    PORT_IC = 1'b0,
    PORT_DC = 1'b1
  } port_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between the I-cache and D-cache request ports.
module mem_rr_arbiter
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_ic_i,
  input  logic req_dc_i,
  input  logic accept_i,
  output logic gnt_ic_o,
  output logic gnt_dc_o
);

  port_t last_q;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt_ic_o = req_ic_i && (!req_dc_i || (last_q == PORT_DC));
    gnt_dc_o = req_dc_i && !gnt_ic_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_IC;
    end else if (accept_i) begin
      last_q <= gnt_dc_o ? PORT_DC : PORT_IC;
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Serialises cache line fills/writebacks into single-word memory bus transactions.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ic_req_valid,
  output logic                         ic_req_ready,
  input  logic [ADDR_W-1:0]            ic_req_addr,
  output logic                         ic_resp_valid,
  output logic [LINE_WORDS*WORD_W-1:0] ic_resp_line,
  input  logic                         dc_req_valid,
  output logic                         dc_req_ready,
  input  logic                         dc_req_we,
  input  logic [ADDR_W-1:0]            dc_req_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] dc_req_line,
  output logic                         dc_resp_valid,
  output logic [LINE_WORDS*WORD_W-1:0] dc_resp_line,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WORD_W-1:0]            mem_wdata,
  input  logic                         mem_rvalid,
  input  logic [WORD_W-1:0]            mem_rdata,
  output logic                         err
);

  localparam int unsigned WBYTES = WORD_W / 8;
  localparam int unsigned OFFB   = $clog2(LINE_WORDS * WBYTES);
  localparam int unsigned WSH    = $clog2(WBYTES);
  localparam int unsigned IW     = $clog2(LINE_WORDS);
  localparam int unsigned CW     = IW + 1;

  localparam logic [CW-1:0]     FULL_CNT = CW'(LINE_WORDS);
  localparam logic [CW-1:0]     LAST_IDX = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFFB) - 64'd1);

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] buf_t;

  resp_state_t       state_q, state_d;
  port_t             port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  buf_t              line_q, line_d;
  buf_t              ic_line_q, ic_line_d;
  buf_t              dc_line_q, dc_line_d;
  logic [CW-1:0]     issue_q, issue_d;
  logic [CW-1:0]     recv_q, recv_d;
  logic              err_q, err_d;

  logic              gnt_ic, gnt_dc;
  logic              ic_acc, dc_acc;
  logic [ADDR_W-1:0] addr_sel;

  mem_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_ic_i (ic_req_valid),
    .req_dc_i (dc_req_valid),
    .accept_i (ic_acc || dc_acc),
    .gnt_ic_o (gnt_ic),
    .gnt_dc_o (gnt_dc)
  );

  always_comb begin
    ic_req_ready = (state_q == IDLE) && gnt_ic;
    dc_req_ready = (state_q == IDLE) && gnt_dc;
    ic_acc       = ic_req_valid && ic_req_ready;
    dc_acc       = dc_req_valid && dc_req_ready;
    addr_sel     = dc_acc ? dc_req_addr : ic_req_addr;
  end

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    base_d    = base_q;
    line_d    = line_q;
    ic_line_d = ic_line_q;
    dc_line_d = dc_line_q;
    issue_d   = issue_q;
    recv_d    = recv_q;
    err_d     = err_q;

    // Read capture runs independently of issue so returns may overlap ISSUE.
    if (mem_rvalid) begin
      if (((state_q == ISSUE) || (state_q == DRAIN)) && !we_q && (recv_q != FULL_CNT)) begin
        line_d[recv_q[IW-1:0]] = mem_rdata;
        recv_d                 = recv_q + CW'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (ic_acc || dc_acc) begin
          port_d  = dc_acc ? PORT_DC : PORT_IC;
          we_d    = dc_acc && dc_req_we;
          base_d  = addr_sel & ~OFF_MASK;
          line_d  = dc_acc ? buf_t'(dc_req_line) : '0;
          issue_d = '0;
          recv_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          issue_d = issue_q + CW'(1);
          if (issue_q == LAST_IDX) begin
            if (we_q || (recv_d == FULL_CNT)) begin
              state_d = RESP;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (recv_d == FULL_CNT) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Response lines are snapshotted on entry to RESP and held until that port's next response.
    if ((state_d == RESP) && (state_q != RESP)) begin
      if (port_q == PORT_DC) begin
        dc_line_d = line_d;
      end else begin
        ic_line_d = line_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      port_q    <= PORT_IC;
      we_q      <= 1'b0;
      base_q    <= '0;
      line_q    <= '0;
      ic_line_q <= '0;
      dc_line_q <= '0;
      issue_q   <= '0;
      recv_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      base_q    <= base_d;
      line_q    <= line_d;
      ic_line_q <= ic_line_d;
      dc_line_q <= dc_line_d;
      issue_q   <= issue_d;
      recv_q    <= recv_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    mem_valid     = (state_q == ISSUE);
    mem_we        = mem_valid && we_q;
    mem_addr      = base_q + (ADDR_W'(issue_q[IW-1:0]) << WSH);
    mem_wdata     = line_q[issue_q[IW-1:0]];
    ic_resp_valid = (state_q == RESP) && (port_q == PORT_IC);
    dc_resp_valid = (state_q == RESP) && (port_q == PORT_DC);
    ic_resp_line  = ic_line_q;
    dc_resp_line  = dc_line_q;
    err           = err_q;
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: directed table, corner sequences, randomized traffic.
module tb_mem_line_responder;
  import mem_pkg::*;

  localparam int unsigned AW = DEF_ADDR_W;
  localparam int unsigned WW = DEF_WORD_W;
  localparam int unsigned LW = DEF_LINE_WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_req_valid = 1'b0, ic_req_ready;
  logic [AW-1:0] ic_req_addr = '0;
  logic          ic_resp_valid;
  line_t         ic_resp_line;
  logic          dc_req_valid = 1'b0, dc_req_ready, dc_req_we = 1'b0;
  logic [AW-1:0] dc_req_addr = '0;
  line_t         dc_req_line = '0;
  logic          dc_resp_valid;
  line_t         dc_resp_line;
  logic          mem_valid, mem_we;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata, mem_rdata = '0;
  logic          err;

  mem_line_responder #(.ADDR_W(AW), .WORD_W(WW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_line(ic_resp_line),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_line(dc_req_line),
    .dc_resp_valid(dc_resp_valid), .dc_resp_line(dc_resp_line),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: configurable accept stall and read latency; read data is a function of the address.
  int unsigned stall_cfg = 0, lat_cfg = 0;
  bit          extra_cfg = 1'b0;
  logic [31:0] salt = '0;
  int unsigned words_acc = 0;

  typedef struct { logic [WW-1:0] data; int unsigned due; } rd_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [WW-1:0] wdata; } bus_t;
  rd_t  pend[$];
  bus_t exp_bus[$];
  bit   grant_q[$];

  function automatic logic [WW-1:0] mdata(input logic [AW-1:0] a);
    return a[31:0] ^ salt;
  endfunction

  function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
    return a - (a % AW'(LW * WW / 8));
  endfunction

  initial begin : mem_model
    int unsigned wait_cnt;
    bit have_prev;
    logic [AW-1:0] prev_addr;
    logic [WW-1:0] prev_wdata;
    logic prev_we;
    bus_t e;
    wait_cnt = 0;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; wait_cnt = 0; have_prev = 1'b0;
        pend.delete(); exp_bus.delete();
        continue;
      end
      if (have_prev) begin
        chk("hold_valid", 256'(mem_valid), 256'(1'b1));
        chk("hold_addr", 256'(mem_addr), 256'(prev_addr));
        chk("hold_wdata", 256'({mem_we, mem_wdata}), 256'({prev_we, prev_wdata}));
      end
      have_prev = 1'b0;
      mem_ready = (wait_cnt >= stall_cfg);
      if (mem_valid) begin
        if (mem_ready) begin
          wait_cnt = 0;
          words_acc++;
          if (exp_bus.size() == 0) begin
            chk("bus_unexpected", 256'(mem_addr), 256'(0));
          end else begin
            e = exp_bus.pop_front();
            chk("bus_we", 256'(mem_we), 256'(e.we));
            chk("bus_addr", 256'(mem_addr), 256'(e.addr));
            if (e.we) chk("bus_wdata", 256'(mem_wdata), 256'(e.wdata));
          end
          if (!mem_we) begin
            pend.push_back('{mdata(mem_addr), cyc + 1 + lat_cfg});
            if (extra_cfg && (((mem_addr / (WW / 8)) % LW) == LW - 1))
              pend.push_back('{32'hDEAD_BEEF, cyc + 2 + lat_cfg});
          end
        end else begin
          wait_cnt++;
          have_prev = 1'b1;
          prev_addr = mem_addr; prev_wdata = mem_wdata; prev_we = mem_we;
        end
      end else begin
        wait_cnt = 0;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend[0].data;
        void'(pend.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end
  end

  initial begin : ready_monitor
    forever begin
      @(negedge clk);
      #2;
      if (ic_req_valid && dc_req_valid)
        chk("one_ready", 256'(ic_req_ready && dc_req_ready), 256'(0));
    end
  end

  task automatic do_req(input bit dc, input bit we, input logic [AW-1:0] addr, input line_t wline,
                        input line_t exp_line, input int unsigned exp_lat, input string nm);
    int unsigned t;
    bit got;
    logic [AW-1:0] b;
    @(negedge clk);
    if (dc) begin
      dc_req_valid = 1'b1; dc_req_we = we; dc_req_addr = addr; dc_req_line = wline;
    end else begin
      ic_req_valid = 1'b1; ic_req_addr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      #1;
      if (dc ? dc_req_ready : ic_req_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk({nm, "_accept"}, 256'(got), 256'(1'b1));
    if (!got) begin
      if (dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
      return;
    end
    t = cyc;
    grant_q.push_back(dc);
    b = line_base(addr);
    for (int i = 0; i < LW; i++)
      exp_bus.push_back('{we, b + AW'(i * (WW / 8)), wline[i]});
    @(negedge clk);
    if (dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      #1;
      if (dc ? dc_resp_valid : ic_resp_valid) begin
        got = 1'b1;
        chk({nm, "_line"}, 256'(dc ? dc_resp_line : ic_resp_line), 256'(exp_line));
        chk({nm, "_other"}, 256'(dc ? ic_resp_valid : dc_resp_valid), 256'(0));
        if (exp_lat != 0) chk({nm, "_lat"}, 256'(cyc - t), 256'(exp_lat));
      end else begin
        @(negedge clk);
      end
    end
    chk({nm, "_resp"}, 256'(got), 256'(1'b1));
    if (got) begin
      @(negedge clk);
      #1;
      chk({nm, "_pulse"}, 256'(dc ? dc_resp_valid : ic_resp_valid), 256'(0));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit dc; bit we; logic [AW-1:0] addr; line_t wline;
    int unsigned stall; int unsigned lat; line_t exp_line; int unsigned exp_lat;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[5];
    line_t l, wl, el;
    logic [AW-1:0] a, b;
    int unsigned start;
    bit seen;

    vt[0] = '{1'b0, 1'b0, 36'h0_0000_1234, '0, 0, 0,
              line_t'({32'h123C, 32'h1238, 32'h1234, 32'h1230}), 6};
    vt[1] = '{1'b1, 1'b1, 36'h0_0000_0040, line_t'({32'd4, 32'd3, 32'd2, 32'd1}), 0, 0,
              line_t'({32'd4, 32'd3, 32'd2, 32'd1}), 5};
    vt[2] = '{1'b1, 1'b0, 36'h7_FFFF_FFF8, '0, 0, 0,
              line_t'({32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF0}), 6};
    vt[3] = '{1'b0, 1'b0, 36'h0_0000_2000, '0, 3, 5,
              line_t'({32'h200C, 32'h2008, 32'h2004, 32'h2000}), 0};
    vt[4] = '{1'b1, 1'b1, 36'hA_0000_0017,
              line_t'({32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}), 2, 0,
              line_t'({32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}), 0};

    #1;
    chk("reset_outputs",
        256'({ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_valid, mem_we, err,
              mem_addr, mem_wdata, ic_resp_line, dc_resp_line}), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      stall_cfg = vt[i].stall;
      lat_cfg   = vt[i].lat;
      do_req(vt[i].dc, vt[i].we, vt[i].addr, vt[i].wline, vt[i].exp_line, vt[i].exp_lat,
             $sformatf("vec%0d", i));
    end
    chk("no_err_after_vectors", 256'(err), 256'(0));

    // Contention from reset release, then a second simultaneous round.
    stall_cfg = 0; lat_cfg = 1;
    grant_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    fork
      do_req(1'b1, 1'b0, 36'h100, '0, line_t'({32'h10C, 32'h108, 32'h104, 32'h100}), 0, "cont_dc0");
      do_req(1'b0, 1'b0, 36'h200, '0, line_t'({32'h20C, 32'h208, 32'h204, 32'h200}), 0, "cont_ic0");
      begin rst_n = 1'b1; end
    join
    fork
      do_req(1'b1, 1'b1, 36'h300, line_t'({32'h33, 32'h32, 32'h31, 32'h30}),
             line_t'({32'h33, 32'h32, 32'h31, 32'h30}), 0, "cont_dc1");
      do_req(1'b0, 1'b0, 36'h400, '0, line_t'({32'h40C, 32'h408, 32'h404, 32'h400}), 0, "cont_ic1");
    join
    chk("grant_count", 256'(grant_q.size()), 256'(4));
    if (grant_q.size() == 4)
      chk("grant_order", 256'({grant_q[0], grant_q[1], grant_q[2], grant_q[3]}), 256'(4'b1010));

    // Extra fifth read word lands during RESP.
    lat_cfg = 0; extra_cfg = 1'b1;
    el = line_t'({32'h50C, 32'h508, 32'h504, 32'h500});
    chk("err_before_extra", 256'(err), 256'(0));
    do_req(1'b0, 1'b0, 36'h500, '0, el, 6, "extra");
    extra_cfg = 1'b0;
    chk("err_after_extra", 256'(err), 256'(1));
    chk("line_after_extra", 256'(ic_resp_line), 256'(el));
    do_req(1'b1, 1'b1, 36'h600, el, el, 5, "after_err");
    chk("err_sticky", 256'(err), 256'(1));

    // Stray read word while idle.
    do_reset();
    #2;
    chk("err_cleared", 256'(err), 256'(0));
    pend.push_back('{32'h1, cyc});
    @(negedge clk); #2;
    chk("idle_rvalid_driven", 256'(mem_rvalid), 256'(1));
    chk("idle_err_not_yet", 256'(err), 256'(0));
    @(negedge clk); #2;
    chk("idle_err_set", 256'(err), 256'(1));
    repeat (3) @(negedge clk);
    #2;
    chk("idle_err_sticky", 256'(err), 256'(1));

    // Reset while a read is in flight.
    do_reset();
    stall_cfg = 0; lat_cfg = 2;
    ic_req_valid = 1'b1; ic_req_addr = 36'h800;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (ic_req_ready) seen = 1'b1; else @(negedge clk);
    end
    chk("abort_accept", 256'(seen), 256'(1));
    for (int i = 0; i < LW; i++) exp_bus.push_back('{1'b0, AW'(36'h800 + i * 4), '0});
    start = words_acc;
    @(negedge clk);
    ic_req_valid = 1'b0;
    for (int i = 0; i < 20 && words_acc < start + 2; i++) @(negedge clk);
    chk("abort_words_issued", 256'(words_acc - start), 256'(2));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero",
        256'({ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_valid, mem_we, err,
              mem_addr, mem_wdata, ic_resp_line, dc_resp_line}), 256'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("abort_no_resp", 256'({ic_resp_valid, dc_resp_valid}), 256'(0));
    end
    rst_n = 1'b1;
    lat_cfg = 0;
    do_req(1'b0, 1'b0, 36'h900, '0, line_t'({32'h90C, 32'h908, 32'h904, 32'h900}), 6, "post_abort");
    chk("post_abort_err", 256'(err), 256'(0));

    // Randomized traffic against the address-function memory model.
    for (int n = 0; n < 40; n++) begin
      bit dc, we;
      dc = 1'($urandom);
      we = dc ? 1'($urandom) : 1'b0;
      a = {4'($urandom), 32'($urandom)};
      for (int i = 0; i < LW; i++) wl[i] = $urandom;
      stall_cfg = $urandom_range(0, 2);
      lat_cfg   = $urandom_range(0, 3);
      salt      = $urandom;
      b = line_base(a);
      for (int i = 0; i < LW; i++) l[i] = mdata(b + AW'(i * (WW / 8)));
      el = we ? wl : l;
      do_req(dc, we, a, wl, el, (stall_cfg == 0) ? (we ? 5 : 6 + lat_cfg) : 0,
             $sformatf("rnd%0d", n));
    end
    chk("rnd_err", 256'(err), 256'(0));
    chk("bus_queue_empty", 256'(exp_bus.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
